// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: one-entry buffered words shifted out MSB-first, then idle gap.
// Optional even-parity bit after the LSB when SERIAL_TX_PARITY_EN is defined.
module serial_tx #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                  fastClk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] wordIn,
    input  logic                  wordValid,
    output logic                  wordReady,
    output logic                  dataOut,
    output logic                  frameStart,
    output logic                  busy
);

    localparam int unsigned BitW = $clog2(DATA_WIDTH);
    localparam int unsigned GapW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BitW-1:0] BitLast = BitW'(DATA_WIDTH - 1);
    localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
`ifdef SERIAL_TX_PARITY_EN
        StPar,
`endif
        StGap
    } state_e;

    state_e                stateQ, stateD;
    logic [DATA_WIDTH-1:0] bufWordQ, bufWordD;
    logic                  bufFullQ, bufFullD;
    logic [DATA_WIDTH-1:0] shifterQ, shifterD;
    logic [BitW-1:0]       bitCntQ, bitCntD;
    logic [GapW-1:0]       gapCntQ, gapCntD;
    logic                  dataOutQ, dataOutD;
    logic                  frameStartQ, frameStartD;
    logic                  busyQ, busyD;
`ifdef SERIAL_TX_PARITY_EN
    logic                  parityQ, parityD;
`endif
    logic                  load;
    logic                  afterData;
    logic                  endFrame;

    always_comb begin
        stateD      = stateQ;
        bufWordD    = bufWordQ;
        bufFullD    = bufFullQ;
        shifterD    = shifterQ;
        bitCntD     = bitCntQ;
        gapCntD     = gapCntQ;
        dataOutD    = 1'b0;
        frameStartD = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        parityD     = parityQ;
`endif
        load        = 1'b0;
        afterData   = 1'b0;
        endFrame    = 1'b0;

        unique case (stateQ)
            StIdle: load = bufFullQ;
            StShift: begin
                if (bitCntQ != '0) begin
                    dataOutD = shifterQ[DATA_WIDTH-1];
                    shifterD = {shifterQ[DATA_WIDTH-2:0], 1'b0};
                    bitCntD  = bitCntQ - BitW'(1);
                end else begin
`ifdef SERIAL_TX_PARITY_EN
                    stateD   = StPar;
                    dataOutD = parityQ;
`else
                    afterData = 1'b1;
`endif
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            StPar: afterData = 1'b1;
`endif
            StGap: begin
                if (gapCntQ != '0) begin
                    gapCntD = gapCntQ - GapW'(1);
                end else begin
                    endFrame = 1'b1;
                end
            end
            default: stateD = StIdle;
        endcase

        if (afterData) begin
            if (GAP_CYCLES > 0) begin
                stateD  = StGap;
                gapCntD = GapLast;
            end else begin
                endFrame = 1'b1;
            end
        end

        // Back-to-back frames reload straight into SHIFT with no idle cycle.
        if (endFrame) begin
            if (bufFullQ) begin
                load = 1'b1;
            end else begin
                stateD = StIdle;
            end
        end

        // The MSB goes straight to the line register; the shifter holds the remaining bits.
        if (load) begin
            stateD      = StShift;
            bufFullD    = 1'b0;
            dataOutD    = bufWordQ[DATA_WIDTH-1];
            shifterD    = {bufWordQ[DATA_WIDTH-2:0], 1'b0};
            bitCntD     = BitLast;
            frameStartD = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            parityD     = ^bufWordQ;
`endif
        end

        if (wordValid && !bufFullQ) begin
            bufFullD = 1'b1;
            bufWordD = wordIn;
        end

        busyD = (stateD != StIdle);
    end

    always_ff @(posedge fastClk) begin
        if (!reset) begin
            stateQ      <= StIdle;
            bufWordQ    <= '0;
            bufFullQ    <= 1'b0;
            shifterQ    <= '0;
            bitCntQ     <= '0;
            gapCntQ     <= '0;
            dataOutQ    <= 1'b0;
            frameStartQ <= 1'b0;
            busyQ       <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parityQ     <= 1'b0;
`endif
        end else begin
            stateQ      <= stateD;
            bufWordQ    <= bufWordD;
            bufFullQ    <= bufFullD;
            shifterQ    <= shifterD;
            bitCntQ     <= bitCntD;
            gapCntQ     <= gapCntD;
            dataOutQ    <= dataOutD;
            frameStartQ <= frameStartD;
            busyQ       <= busyD;
`ifdef SERIAL_TX_PARITY_EN
            parityQ     <= parityD;
`endif
        end
    end

    assign wordReady  = !bufFullQ;
    assign dataOut    = dataOutQ;
    assign frameStart = frameStartQ;
    assign busy       = busyQ;

endmodule
